// File: rtl/rd_addr_gen.sv
// Read-side address generator and sequencer for a two-bank radix-2 DIF FFT.
// Walks stages/butterflies, maps operand pairs to conflict-free bank addresses.
module rd_addr_gen #(
    parameter int LOG2N = 4,
    parameter int GAP   = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [LOG2N-2:0]           addr_BANK0,
    output logic [LOG2N-2:0]           addr_BANK1,
    output logic                       sel_rd_swap,
    output logic                       en_REG_RD,
    output logic [LOG2N-2:0]           tw_idx,
    output logic [$clog2(LOG2N)-1:0]   stage_out,
    output logic                       op_valid
);

    localparam int KW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [GW-1:0] G_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k;
    logic [SW-1:0]   s;
    logic [GW-1:0]   g;

    logic [SW-1:0]    p;
    logic [LOG2N-1:0] kx, one_p, low_mask, idx_a, idx_b, tw_full;
    logic             sel;
    logic [KW-1:0]    tw;
    logic [KW-1:0]    tw_d1;
    logic [SW-1:0]    stg_d1;

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_READ;
            S_READ: begin
                if (k == K_LAST) begin
                    if (s == S_LAST)  state_nxt = S_DONE;
                    else if (GAP == 0) state_nxt = S_READ;
                    else              state_nxt = S_GAP;
                end
            end
            S_GAP:  if (g == G_LAST) state_nxt = S_READ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            k <= '0;
            s <= '0;
            g <= '0;
        end else begin
            case (state)
                S_READ: begin
                    g <= '0;
                    if (k == K_LAST) begin
                        k <= '0;
                        s <= (s == S_LAST) ? '0 : s + SW'(1);
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                S_GAP:  g <= g + GW'(1);
                S_DONE: ;
                default: begin
                    k <= '0;
                    s <= '0;
                    g <= '0;
                end
            endcase
        end
    end

    // Pair indices: insert a 0 (a) or 1 (b) at pivot bit p of k.
    always_comb begin
        p        = S_LAST - s;
        kx       = {1'b0, k};
        one_p    = LOG2N'(1) << p;
        low_mask = one_p - LOG2N'(1);
        idx_a    = (((kx >> p) << p) << 1) | (kx & low_mask);
        idx_b    = idx_a | one_p;
        sel      = ~(^idx_a);
        tw_full  = (kx & low_mask) << s;
        tw       = tw_full[KW-1:0];
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign rd_en = (state == S_READ);

    always_comb begin
        addr_BANK0 = '0;
        addr_BANK1 = '0;
        if (rd_en) begin
            addr_BANK0 = sel ? idx_a[LOG2N-1:1] : idx_b[LOG2N-1:1];
            addr_BANK1 = sel ? idx_b[LOG2N-1:1] : idx_a[LOG2N-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            en_REG_RD   <= 1'b0;
            sel_rd_swap <= 1'b0;
            tw_d1       <= '0;
            stg_d1      <= '0;
            op_valid    <= 1'b0;
            tw_idx      <= '0;
            stage_out   <= '0;
        end else begin
            en_REG_RD   <= rd_en;
            sel_rd_swap <= rd_en & sel;
            tw_d1       <= rd_en ? tw : '0;
            stg_d1      <= rd_en ? s : '0;
            op_valid    <= en_REG_RD;
            tw_idx      <= tw_d1;
            stage_out   <= stg_d1;
        end
    end

endmodule

// File: tb/tb_rd_addr_gen.sv
// Scoreboard bench for rd_addr_gen: schedule, addresses, swap/twiddle alignment,
// per-stage coverage, disruptions and a GAP=0 instance.
module tb_rd_addr_gen;

    localparam int LEN    = 8;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn = 1'b0, start = 1'b0, start0 = 1'b0;

    logic       busy, done, rd_en, sel_rd_swap, en_REG_RD, op_valid;
    logic [2:0] addr_BANK0, addr_BANK1, tw_idx;
    logic [1:0] stage_out;

    logic       busy_z, done_z, rd_en_z, sel_z, en_z, op_z;
    logic [2:0] a0_z, a1_z, tw_z;
    logic [1:0] st_z;

    rd_addr_gen #(.LOG2N(4), .GAP(2)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .addr_BANK0(addr_BANK0), .addr_BANK1(addr_BANK1),
        .sel_rd_swap(sel_rd_swap), .en_REG_RD(en_REG_RD), .tw_idx(tw_idx),
        .stage_out(stage_out), .op_valid(op_valid)
    );

    rd_addr_gen #(.LOG2N(4), .GAP(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .busy(busy_z), .done(done_z),
        .rd_en(rd_en_z), .addr_BANK0(a0_z), .addr_BANK1(a1_z),
        .sel_rd_swap(sel_z), .en_REG_RD(en_z), .tw_idx(tw_z),
        .stage_out(st_z), .op_valid(op_z)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         due;
        logic       sel;
        logic [2:0] tw;
        logic [1:0] st;
    } exp_t;

    exp_t swap_q[$];
    exp_t op_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ins_zero(input logic [2:0] k, input int p);
        logic [3:0] a;
        a = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < p)      a[j] = k[j];
            else if (j > p) a[j] = k[j-1];
        end
        return a;
    endfunction

    function automatic bit par4(input logic [3:0] x);
        int c;
        c = 0;
        for (int j = 0; j < 4; j++) if (x[j]) c++;
        return c[0];
    endfunction

    task automatic sched(input int r, input int g, output bit rd, output bit dn,
                         output bit bz, output int s, output int k);
        int per, last;
        per  = LEN + g;
        last = STAGES * LEN + (STAGES - 1) * g;
        rd   = (r >= 1) && (r <= last) && (((r - 1) % per) < LEN);
        s    = (r - 1) / per;
        k    = (r - 1) % per;
        dn   = (r == last + 1);
        bz   = (r >= 1) && (r <= last + 1);
    endtask

    // Full GAP=2 run with scoreboarded pipeline outputs; optional stray starts.
    task automatic run_check(input bit disrupt, input string tag);
        int seen[16];
        bit rd, dn, bz, exp_en, exp_op;
        int s, k, p;
        logic [3:0] a, b, x0, x1, t;
        logic esel;
        logic [2:0] ea0, ea1, etw;
        exp_t e;
        swap_q.delete();
        op_q.delete();
        foreach (seen[i]) seen[i] = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int r = 1; r <= 44; r++) begin
            sched(r, 2, rd, dn, bz, s, k);
            checks++;
            if ({rd_en, busy, done} !== {rd, bz, dn}) begin
                failures++;
                $display("FAIL %s ctrl r=%0d {rd_en,busy,done} got=%b exp=%b", tag, r,
                         {rd_en, busy, done}, {rd, bz, dn});
            end
            exp_en = (swap_q.size() > 0) && (swap_q[0].due == r);
            checks++;
            if (en_REG_RD !== exp_en) begin
                failures++;
                $display("FAIL %s en_REG_RD r=%0d got=%b exp=%b", tag, r, en_REG_RD, exp_en);
            end
            if (exp_en) begin
                e = swap_q.pop_front();
                checks++;
                if (sel_rd_swap !== e.sel) begin
                    failures++;
                    $display("FAIL %s sel_rd_swap r=%0d got=%b exp=%b", tag, r, sel_rd_swap, e.sel);
                end
            end
            exp_op = (op_q.size() > 0) && (op_q[0].due == r);
            checks++;
            if (op_valid !== exp_op) begin
                failures++;
                $display("FAIL %s op_valid r=%0d got=%b exp=%b", tag, r, op_valid, exp_op);
            end
            if (exp_op) begin
                e = op_q.pop_front();
                checks++;
                if ({tw_idx, stage_out} !== {e.tw, e.st}) begin
                    failures++;
                    $display("FAIL %s tw/stage r=%0d got=%0d/%0d exp=%0d/%0d", tag, r,
                             tw_idx, stage_out, e.tw, e.st);
                end
            end
            if (rd) begin
                p    = 3 - s;
                a    = ins_zero(3'(k), p);
                b    = a | 4'(1 << p);
                esel = !par4(a);
                ea0  = esel ? a[3:1] : b[3:1];
                ea1  = esel ? b[3:1] : a[3:1];
                t    = (4'(k) & 4'((1 << p) - 1)) << s;
                etw  = t[2:0];
                checks++;
                if ({addr_BANK0, addr_BANK1} !== {ea0, ea1}) begin
                    failures++;
                    $display("FAIL %s addr r=%0d s=%0d k=%0d got=%0d/%0d exp=%0d/%0d", tag, r, s, k,
                             addr_BANK0, addr_BANK1, ea0, ea1);
                end
                swap_q.push_back('{r + 1, esel, 3'd0, 2'd0});
                op_q.push_back('{r + 2, 1'b0, etw, 2'(s)});
                // Rebuild the true index from each bank's address and that bank's parity.
                x0 = {addr_BANK0, ^addr_BANK0};
                x1 = {addr_BANK1, ~^addr_BANK1};
                seen[x0]++;
                seen[x1]++;
                if (k == LEN - 1) begin
                    for (int i = 0; i < 16; i++) begin
                        checks++;
                        if (seen[i] != 1) begin
                            failures++;
                            $display("FAIL %s coverage s=%0d idx=%0d got=%0d exp=1", tag, s, i, seen[i]);
                        end
                        seen[i] = 0;
                    end
                end
            end else begin
                checks++;
                if ({addr_BANK0, addr_BANK1} !== 6'd0) begin
                    failures++;
                    $display("FAIL %s addr_idle r=%0d got=%0d/%0d exp=0/0", tag, r,
                             addr_BANK0, addr_BANK1);
                end
            end
            start = disrupt && (r == 4 || r == 9 || r == 19 || r == 35);
            tick;
        end
        start = 1'b0;
        checks++;
        if (swap_q.size() + op_q.size() != 0) begin
            failures++;
            $display("FAIL %s drain got=%0d exp=0", tag, swap_q.size() + op_q.size());
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        tick;
        tick;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done, rd_en, addr_BANK0, addr_BANK1, sel_rd_swap, en_REG_RD,
                 tw_idx, stage_out, op_valid} !== 17'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, {busy, done, rd_en,
                         addr_BANK0, addr_BANK1, sel_rd_swap, en_REG_RD, tw_idx, stage_out, op_valid});
            end
            checks++;
            if ({busy_z, done_z, rd_en_z, a0_z, a1_z, sel_z, en_z, tw_z, st_z, op_z} !== 17'd0) begin
                failures++;
                $display("FAIL reset_idle_gap0 cyc=%0d got=%h exp=0", i,
                         {busy_z, done_z, rd_en_z, a0_z, a1_z, sel_z, en_z, tw_z, st_z, op_z});
            end
            tick;
        end
    endtask

    task automatic test_full_run;
        run_check(1'b0, "full_run");
    endtask

    task automatic test_disrupt_start;
        run_check(1'b1, "disrupt");
    endtask

    task automatic test_spot;
        int         sr[4]  = '{1, 6, 14, 32};
        logic [2:0] sa0[4] = '{3'd0, 3'd2, 3'd1, 3'd1};
        logic [2:0] sa1[4] = '{3'd4, 3'd6, 3'd3, 3'd1};
        logic       ssw[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] stw[4] = '{3'd0, 3'd5, 3'd6, 3'd0};
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int r = 1; r <= 44; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (r == sr[i]) begin
                    checks++;
                    if ({addr_BANK0, addr_BANK1} !== {sa0[i], sa1[i]}) begin
                        failures++;
                        $display("FAIL spot_addr r=%0d got=%0d/%0d exp=%0d/%0d", r,
                                 addr_BANK0, addr_BANK1, sa0[i], sa1[i]);
                    end
                end
                if (r == sr[i] + 1) begin
                    checks++;
                    if ({en_REG_RD, sel_rd_swap} !== {1'b1, ssw[i]}) begin
                        failures++;
                        $display("FAIL spot_swap r=%0d got=%b exp=%b", r,
                                 {en_REG_RD, sel_rd_swap}, {1'b1, ssw[i]});
                    end
                end
                if (r == sr[i] + 2) begin
                    checks++;
                    if ({op_valid, tw_idx} !== {1'b1, stw[i]}) begin
                        failures++;
                        $display("FAIL spot_tw r=%0d got=%b exp=%b", r,
                                 {op_valid, tw_idx}, {1'b1, stw[i]});
                    end
                end
            end
            tick;
        end
    endtask

    task automatic test_reset_midrun;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick;
        rstn = 1'b0;
        tick;
        checks++;
        if ({busy, done, rd_en, addr_BANK0, addr_BANK1, sel_rd_swap, en_REG_RD,
             tw_idx, stage_out, op_valid} !== 17'd0) begin
            failures++;
            $display("FAIL midrun_reset got=%h exp=0", {busy, done, rd_en, addr_BANK0,
                     addr_BANK1, sel_rd_swap, en_REG_RD, tw_idx, stage_out, op_valid});
        end
        rstn = 1'b1;
        tick;
        checks++;
        if ({busy, rd_en, op_valid} !== 3'b000) begin
            failures++;
            $display("FAIL midrun_idle got=%b exp=000", {busy, rd_en, op_valid});
        end
        run_check(1'b0, "after_reset");
    endtask

    task automatic test_gap0;
        bit rd, dn, bz;
        int s, k, n_rd, n_op;
        n_rd = 0;
        n_op = 0;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int r = 1; r <= 38; r++) begin
            sched(r, 0, rd, dn, bz, s, k);
            checks++;
            if ({rd_en_z, busy_z, done_z} !== {rd, bz, dn}) begin
                failures++;
                $display("FAIL gap0_ctrl r=%0d got=%b exp=%b", r, {rd_en_z, busy_z, done_z}, {rd, bz, dn});
            end
            if (rd_en_z) n_rd++;
            if (op_z) n_op++;
            tick;
        end
        checks++;
        if (n_rd != 32 || n_op != 32) begin
            failures++;
            $display("FAIL gap0_counts got=%0d/%0d exp=32/32", n_rd, n_op);
        end
    endtask

    initial begin
        test_reset;
        test_full_run;
        test_disrupt_start;
        test_spot;
        test_reset_midrun;
        test_gap0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_addr_gen.md
# rd_addr_gen

Read-side address generator and sequencer for the memory-based radix-2 DIF FFT with two single-read-port data banks. It walks every stage and butterfly, maps each butterfly's two operand indices to conflict-free (bank, address) pairs, and drives the bank read ports. It also generates the capture-enable and swap controls for the downstream read-register stage, so that register A always holds the upper operand (index a) and register B the lower (index b). Twiddle index and stage number are delayed to line up with the registered operands.

## Interface
- LOG2N, 4: log2 of FFT size N; N/2 butterflies per stage, LOG2N stages.
- GAP, 2: idle cycles inserted between stages (write-back drain); 0 is legal.
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to run a full FFT; honoured only in IDLE.
- busy  out  1  high in READ, GAP, DONE.
- done  out  1  one-cycle pulse in DONE.
- rd_en  out  1  bank read enable, high in every READ cycle.
- addr_BANK0  out  LOG2N-1  bank-0 read address.
- addr_BANK1  out  LOG2N-1  bank-1 read address.
- sel_rd_swap  out  1  to read-register stage; 1 = index a resides in bank 0.
- en_REG_RD  out  1  capture enable for read-register stage.
- tw_idx  out  LOG2N-1  twiddle exponent, aligned with registered operands.
- stage_out  out  clog2(LOG2N)  stage number, aligned with tw_idx.
- op_valid  out  1  registered operands valid this cycle.

## Operation
- FSM: IDLE -> READ on start; READ -> READ while k < N/2-1; at k = N/2-1: last stage -> DONE, else GAP (or READ directly if GAP=0); GAP -> READ after GAP cycles; DONE -> IDLE after 1 cycle.
- Counters: butterfly k (LOG2N-1 bits), stage s, gap counter. k wraps to 0 and s increments on leaving the last butterfly of a stage.
- Pivot bit p = LOG2N-1-s. a = ((k >> p) << (p+1)) | (k & (2^p-1)). b = a | (1 << p).
- Bank of index x = XOR-reduction of x. a and b always differ in exactly one bit, so they always land in different banks. Within a bank, address = x >> 1.
- sel (cycle-0 value) = ~parity(a). addr_BANK0 = (sel ? a : b) >> 1. addr_BANK1 = (sel ? b : a) >> 1.
- Twiddle = (k & (2^p-1)) << s, truncated to LOG2N-1 bits.
- start while not IDLE: ignored. rstn low at any point: all state and pipeline regs clear, FSM returns to IDLE, and any in-flight op_valid is killed.
- Reset values of outputs: all 0.

## Timing
- Bank read latency is 1 cycle; the read-register stage adds 1 more.
- Cycle t: READ with (k, s); rd_en=1; addresses valid.
- Cycle t+1: en_REG_RD=1; sel_rd_swap equals sel from cycle t.
- Cycle t+2: op_valid=1; tw_idx and stage_out hold the values for (k, s).
- Address outputs are decoded from registered k/s/state only, with no combinational path from start. In non-READ states the addresses hold 0.
- Sequence for LOG2N=4, GAP=2, with start sampled at edge of cycle 0:
  - READ cycles 1–8 (s0), GAP 9–10.
  - READ 11–18 (s1), GAP 19–20.
  - READ 21–28 (s2), GAP 29–30.
  - READ 31–38 (s3), DONE 39, IDLE 40.
- The last op_valid occurs in cycle 40. A start in cycle 40 is accepted.
- rd_en count per run = LOG2N·N/2 = 32. en_REG_RD and op_valid each pulse 32 times.

## Test plan
- Reset then idle: with rstn=0 for 2 cycles, then start=0, all outputs stay 0 and busy=0.
- Full run, LOG2N=4, GAP=2: start at cycle 0 -> rd_en high cycles 1–8, 11–18, 21–28, 31–38; done only in cycle 39; busy 1–39.
- Address and swap spot checks:
  - s0,k0: addr_BANK0=0, addr_BANK1=4, swap=1.
  - s0,k5: addr_BANK0=2, addr_BANK1=6, swap=1, tw_idx=5.
  - s1,k3: addr_BANK0=1, addr_BANK1=3, swap=1, tw_idx=6.
  - s3,k1: addr_BANK0=1, addr_BANK1=1, swap=0, tw_idx=0.
  - In each case swap and tw_idx appear at +1 and +2 respectively.
- Conflict/coverage scoreboard: over each stage, every index 0–15 is read exactly once, and the two indices issued in a READ cycle are never in the same bank.
- Disruptions:
  - start pulses during READ and GAP -> ignored; the cycle count is unchanged.
  - rstn low at cycle 15 -> next cycle all outputs 0, and IDLE.
  - A new start at cycle 17 then completes a clean run, with done 39 cycles later.
- GAP=0: stages run back-to-back; done in cycle 33 for start at 0.
